// File: rtl/fault_inject_ram.sv
// Parametrised fault-injectable RAM for MBIST bring-up: one programmable fault
// (stuck-at, transition or coupling), pipelined synchronous read, activation counter.
module fault_inject_ram #(
  parameter int                AWIDTH   = 4,
  parameter int                DWIDTH   = 4,
  parameter int                RD_LAT   = 1,
  parameter logic [DWIDTH-1:0] INIT_VAL = '1,
  localparam int               BW       = (DWIDTH > 1) ? $clog2(DWIDTH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [AWIDTH-1:0] wr_addr,
  input  logic [DWIDTH-1:0] data_in,
  input  logic              re,
  input  logic [AWIDTH-1:0] rd_addr,
  output logic [DWIDTH-1:0] data_out,
  output logic              rd_valid,
  input  logic              cfg_we,
  input  logic [2:0]        cfg_type,
  input  logic [AWIDTH-1:0] cfg_vaddr,
  input  logic [BW-1:0]     cfg_vbit,
  input  logic [AWIDTH-1:0] cfg_aaddr,
  input  logic [BW-1:0]     cfg_abit,
  output logic              fault_active,
  output logic [15:0]       fault_hits
);

  localparam int DEPTH = 1 << AWIDTH;

  localparam logic [2:0] F_NONE   = 3'd0;
  localparam logic [2:0] F_SA0    = 3'd1;
  localparam logic [2:0] F_SA1    = 3'd2;
  localparam logic [2:0] F_TF_UP  = 3'd3;
  localparam logic [2:0] F_TF_DN  = 3'd4;
  localparam logic [2:0] F_CF_INV = 3'd5;
  localparam logic [2:0] F_CF_ID0 = 3'd6;
  localparam logic [2:0] F_CF_ID1 = 3'd7;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [DWIDTH-1:0] mem [DEPTH];

  logic [2:0]        f_type;
  logic [AWIDTH-1:0] f_vaddr;
  logic [BW-1:0]     f_vbit;
  logic [AWIDTH-1:0] f_aaddr;
  logic [BW-1:0]     f_abit;

  logic [DWIDTH-1:0] old_w;
  logic [DWIDTH-1:0] wr_word;
  logic              wr_hit;
  logic              oth_we;
  logic              oth_bit;
  logic              v_here;
  logic              a_rise;
  logic              cpl_inert;
  logic              old_v;
  logic              ideal_v;
  logic              eff_v;
  logic              is_sa;
  logic              stuck;

  logic [DWIDTH-1:0] rd_raw;
  logic [DWIDTH-1:0] rd_word;
  logic              rd_hit;

  assign is_sa = (f_type == F_SA0) || (f_type == F_SA1);
  assign stuck = (f_type == F_SA1);

  // Write path: ideal word plus fault effects. Under stuck-at faults the array keeps
  // the ideal content of the victim and the stuck value is imposed at the read port.
  always_comb begin
    old_w     = mem[wr_addr];
    old_v     = mem[f_vaddr][f_vbit];
    wr_word   = data_in;
    wr_hit    = 1'b0;
    oth_we    = 1'b0;
    oth_bit   = 1'b0;
    ideal_v   = 1'b0;
    eff_v     = 1'b0;
    v_here    = (wr_addr == f_vaddr);
    a_rise    = (wr_addr == f_aaddr) && !old_w[f_abit] && data_in[f_abit];
    cpl_inert = (f_vaddr == f_aaddr) && (f_vbit == f_abit);
    case (f_type)
      F_SA0, F_SA1: begin
        if (v_here && (data_in[f_vbit] != stuck)) wr_hit = we;
      end
      F_TF_UP: begin
        if (v_here && !old_w[f_vbit] && data_in[f_vbit]) begin
          wr_word[f_vbit] = 1'b0;
          wr_hit          = we;
        end
      end
      F_TF_DN: begin
        if (v_here && old_w[f_vbit] && !data_in[f_vbit]) begin
          wr_word[f_vbit] = 1'b1;
          wr_hit          = we;
        end
      end
      F_CF_INV, F_CF_ID0, F_CF_ID1: begin
        if (a_rise && !cpl_inert) begin
          ideal_v = v_here ? data_in[f_vbit] : old_v;
          eff_v   = (f_type == F_CF_INV) ? ~old_v : (f_type == F_CF_ID1);
          if (v_here) wr_word[f_vbit] = eff_v;
          else begin
            oth_we  = we;
            oth_bit = eff_v;
          end
          wr_hit = we && (eff_v != ideal_v);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_raw  = mem[rd_addr];
    rd_word = rd_raw;
    rd_hit  = 1'b0;
    if (is_sa && (rd_addr == f_vaddr)) begin
      rd_word[f_vbit] = stuck;
      rd_hit          = re && (rd_raw[f_vbit] != stuck);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= INIT_VAL;
    end else begin
      if (we) mem[wr_addr] <= wr_word;
      if (oth_we) mem[f_vaddr][f_vbit] <= oth_bit;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      f_type       <= F_NONE;
      f_vaddr      <= '0;
      f_vbit       <= '0;
      f_aaddr      <= '0;
      f_abit       <= '0;
      fault_active <= 1'b0;
      fault_hits   <= '0;
    end else begin
      if (cfg_we) begin
        f_type       <= cfg_type;
        f_vaddr      <= cfg_vaddr;
        f_vbit       <= cfg_vbit;
        f_aaddr      <= cfg_aaddr;
        f_abit       <= cfg_abit;
        fault_active <= (cfg_type != F_NONE);
        fault_hits   <= '0;
      end else if (wr_hit || rd_hit) begin
        fault_hits <= sat_inc(fault_hits);
      end
    end
  end

  // Read stage p0: word sampled on the re edge
  logic [DWIDTH-1:0] data_p0;
  logic              vld_p0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_p0 <= '0;
      vld_p0  <= 1'b0;
    end else begin
      vld_p0 <= re;
      if (re) data_p0 <= rd_word;
    end
  end

  generate
    if (RD_LAT >= 2) begin : g_lat2
      // Read stage p1: extra register for two-cycle latency
      logic [DWIDTH-1:0] data_p1;
      logic              vld_p1;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          data_p1 <= '0;
          vld_p1  <= 1'b0;
        end else begin
          vld_p1 <= vld_p0;
          if (vld_p0) data_p1 <= data_p0;
        end
      end

      assign data_out = data_p1;
      assign rd_valid = vld_p1;
    end else begin : g_lat1
      assign data_out = data_p0;
      assign rd_valid = vld_p0;
    end
  endgenerate

endmodule

// File: doc/fault_inject_ram.md
Name: fault_inject_ram

Overview:
- Parametrised successor to the team's fixed 4x4, 1-bit fault-injectable RAM; the MBIST controller tests memory through this model.
- Adds configurable data width and depth, a runtime-programmable fault descriptor and a pipelined synchronous read.
- Adds an activation counter, so the bench can check that a march algorithm actually sensitised the injected fault.

Parameters:
- AWIDTH, 4, address width; depth = 2**AWIDTH words.
- DWIDTH, 4, data word width (1..32).
- RD_LAT, 1, read latency in cycles (1 or 2).
- INIT_VAL, all ones, word value loaded into every location on reset.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- we  in  1  write enable.
- wr_addr  in  AWIDTH  write address.
- data_in  in  DWIDTH  write data.
- re  in  1  read enable.
- rd_addr  in  AWIDTH  read address.
- data_out  out  DWIDTH  read data, valid when rd_valid is high.
- rd_valid  out  1  read data valid.
- cfg_we  in  1  load the fault descriptor.
- cfg_type  in  3  fault type code.
- cfg_vaddr  in  AWIDTH  victim word address.
- cfg_vbit  in  clog2(DWIDTH) (min 1)  victim bit index.
- cfg_aaddr  in  AWIDTH  aggressor word address.
- cfg_abit  in  clog2(DWIDTH) (min 1)  aggressor bit index.
- fault_active  out  1  descriptor type is non-zero.
- fault_hits  out  16  saturating count of fault activations.

Behaviour:
- Reset (reset low, asynchronous):
  - every word = INIT_VAL; descriptor type = 0 (NONE), addresses and bits = 0.
  - data_out = 0, rd_valid = 0, fault_hits = 0, fault_active = 0.
  - Read pipeline is flushed; an in-flight read is dropped.
- Config: cfg_we samples all cfg_* fields on the clock edge; the new descriptor governs writes and reads from the next cycle. fault_hits clears on every cfg_we.
- Fault types, applied to victim bit V = mem[cfg_vaddr][cfg_vbit]:
  - 0 NONE: ideal memory.
  - 1 SA0: V reads as 0; writes to V are ignored; other bits of the word are written normally.
  - 2 SA1: as SA0, with V reading as 1.
  - 3 TF_UP: a write that would take V from 0 to 1 leaves V at 0.
  - 4 TF_DN: a write that would take V from 1 to 0 leaves V at 1.
  - 5 CF_INV: a write that takes aggressor bit A from 0 to 1 also inverts V in the same cycle.
  - 6 CF_ID0: a write that takes A from 0 to 1 forces V to 0.
  - 7 CF_ID1: a write that takes A from 0 to 1 forces V to 1.
- Coupling-fault rules:
  - If aggressor and victim share a word, the coupling effect overrides the written value of V.
  - If aggressor == victim (same address and bit), coupling faults are inert.
- Activation: fault_hits increments by 1 for each cycle in which a fault alters a stored or read value versus ideal. This covers:
  - an ignored SA write that differs from the stuck value;
  - a SA read of V whose stored value differs from the stuck value;
  - a blocked transition;
  - a coupling effect that changes V.
- fault_hits saturates at 16'hFFFF.
- Write: when we is high, the word is updated on the edge with faults applied. Out-of-range addresses cannot occur (full decode).
- Read:
  - When re is high, the word is sampled on the edge, SA masking is applied, and the result enters the pipeline.
  - data_out and rd_valid appear RD_LAT cycles after the re edge.
  - rd_valid is high for exactly one cycle per accepted read; back-to-back reads give one result per cycle.
  - data_out holds its last value when rd_valid is low.
- Simultaneous we and re to the same address: the read returns the old data (read-before-write).
- cfg_we in the same cycle as we: the write uses the old descriptor.
- fault_active = (descriptor type != 0), registered.

Test Plan:
- Reset then read all 16 addresses (AWIDTH=4, DWIDTH=4, RD_LAT=1): every data_out = 4'hF, with rd_valid one cycle after each re.
- SA0 at vaddr=5, vbit=2: write 4'hF to address 5, read it -> 4'hB; write 4'h0, read -> 4'h0; fault_hits = 2.
- TF_UP at vaddr=2, vbit=0:
  - write 4'h0 then 4'h1, read -> 4'h0, fault_hits = 1;
  - a write of 4'h0 to a victim already at 1 (after reset) succeeds.
- CF_INV, aggressor (7,3), victim (3,1):
  - write 4'h0 to address 3 and to address 7, then write 4'h8 to address 7 -> address 3 reads 4'h2;
  - a second 4'h8 write to address 7 does not re-toggle.
- RD_LAT=2: reads at addresses 1, 2, 3 on consecutive cycles -> three consecutive valid cycles in order.
- Same-cycle we/re to address 4 (old 4'hF, new 4'h3) returns 4'hF, and the next read returns 4'h3.
- Reset asserted during an in-flight read -> no rd_valid after release.
